// File: rtl/stream_pkg.sv
// Shared types and constants for the stream_frame_tx sample source.
// LFSR constants are only consumed when STREAM_FRAME_TX_THROTTLE_EN is defined.
package stream_pkg;

    parameter int unsigned SAMPLE_W = 16;

    typedef enum logic [0:0] {LOAD, SEND} tx_state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stream_frame_tx_buffer.sv
// Frame storage: one write port, one registered read port, contents not reset.
module frame_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_frame_tx.sv
// Loads one LEN-sample frame, then replays it on a valid/ready master port.
// Define STREAM_FRAME_TX_THROTTLE_EN to add an LFSR-driven m_valid_x stall injector.
module stream_frame_tx
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LEN    = 64,
    parameter int unsigned LOGLEN = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [LOGLEN-1:0] LAST_IDX = LOGLEN'(LEN - 1);

    tx_state_t         state;
    logic [LOGLEN-1:0] wr_cnt;
    logic [LOGLEN-1:0] rd_cnt;
    logic [LOGLEN-1:0] tx_cnt;
    logic              rd_all;
    logic              s_ready_q;

    logic              ram_valid;
    logic [WIDTH-1:0]  ram_data;
    logic              skid_valid;
    logic [WIDTH-1:0]  skid_data;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;

    logic              load_hs_c;
    logic              pop_c;
    logic [1:0]        occ_c;
    logic              issue_c;
    logic              out_free_c;
    logic              stall_c;
    logic              fill_c;
    logic              ram_to_skid_c;

    assign s_ready      = s_ready_q && !reset;
    assign m_valid_x    = out_valid;
    assign m_data_out_x = out_data;

    assign load_hs_c = s_valid && s_ready;
    assign pop_c     = out_valid && m_ready_x;

    // Occupancy left after this cycle's drain; a new read lands next cycle,
    // so at most one slot of out+skid may be taken when issuing.
    assign occ_c   = 2'(out_valid) + 2'(skid_valid) + 2'(ram_valid) - 2'(pop_c);
    assign issue_c = (state == SEND) && !rd_all && (occ_c <= 2'd1);

    assign out_free_c = !out_valid || pop_c;

`ifdef STREAM_FRAME_TX_THROTTLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Never stall when skid and RAM output are both full: the RAM word has nowhere else to go.
    assign stall_c = !lfsr[0] && !(skid_valid && ram_valid);
`else
    assign stall_c = 1'b0;
`endif

    assign fill_c        = out_free_c && !stall_c && (skid_valid || ram_valid);
    assign ram_to_skid_c = ram_valid && !(fill_c && !skid_valid);

    frame_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (LEN),
        .AW    (LOGLEN)
    ) u_buf (
        .clk   (clk),
        .we    (load_hs_c),
        .waddr (wr_cnt),
        .wdata (s_data_in),
        .re    (issue_c),
        .raddr (rd_cnt),
        .rdata (ram_data)
    );

    // Control FSM, counters and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            tx_cnt     <= '0;
            rd_all     <= 1'b0;
            s_ready_q  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (load_hs_c) begin
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt    <= '0;
                            state     <= SEND;
                            s_ready_q <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + LOGLEN'(1);
                        end
                    end
                end
                SEND: begin
                    if (issue_c) begin
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt <= '0;
                            rd_all <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + LOGLEN'(1);
                        end
                    end
                    if (pop_c) begin
                        if (tx_cnt == LAST_IDX) begin
                            tx_cnt     <= '0;
                            rd_cnt     <= '0;
                            rd_all     <= 1'b0;
                            state      <= LOAD;
                            s_ready_q  <= 1'b1;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            tx_cnt <= tx_cnt + LOGLEN'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Read pipeline: RAM output -> skid -> output register, oldest first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            ram_valid <= issue_c;
            if (out_free_c) begin
                out_valid <= fill_c;
                if (fill_c) begin
                    out_data <= skid_valid ? skid_data : ram_data;
                end
            end
            skid_valid <= (skid_valid && !fill_c) || ram_to_skid_c;
            if (ram_to_skid_c) begin
                skid_data <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_tx.sv
// Directed self-checking bench for stream_frame_tx (load/replay, backpressure, reset).
module tb_stream_frame_tx;
    import stream_pkg::*;

    localparam int WIDTH  = 16;
    localparam int LEN    = 64;
    localparam int LOGLEN = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data_in;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;
    logic             busy;
    logic             frame_done;

    int checks = 0;
    int passed = 0;

    sample_t          exp_q [LEN];
    logic [WIDTH-1:0] rx    [LEN];

    int r_n, r_first, r_last, r_stab, r_done_cnt, r_busy_err, r_sready_err, r_dead, r_bubbles, r_thr_err;
    logic r_done_after, r_sready_after, r_mvalid_after;

    stream_frame_tx #(
        .WIDTH  (WIDTH),
        .LEN    (LEN),
        .LOGLEN (LOGLEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in    (s_data_in),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

`ifdef STREAM_FRAME_TX_THROTTLE_EN
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
`endif

    task automatic load_frame();
        for (int i = 0; i < LEN; i++) begin
            s_valid   = 1'b1;
            s_data_in = exp_q[i];
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    // Monitor one SEND phase; mode 0: ready held high, mode 1: ready 1,0,1,0...
    task automatic run_send(input int mode, input bit poke);
        bit               prev_stall;
        bit               prev_free;
        bit               prev_lsb;
        logic [WIDTH-1:0] prev_data;
        prev_stall = 1'b0; prev_free = 1'b0; prev_lsb = 1'b0; prev_data = '0;
        r_n = 0; r_first = -1; r_last = -1; r_stab = 0; r_done_cnt = 0;
        r_busy_err = 0; r_sready_err = 0; r_dead = 0; r_bubbles = 0; r_thr_err = 0;
        r_done_after = 1'b0; r_sready_after = 1'b0; r_mvalid_after = 1'b1;
        for (int k = 0; k < 400; k++) begin
            m_ready_x = (mode == 1) ? (k % 2 == 0) : 1'b1;
            if (poke && r_n < LEN) begin
                s_valid   = 1'b1;
                s_data_in = 16'hDEAD;
            end
            if (m_valid_x && r_first < 0) r_first = k;
            if (prev_stall && (!m_valid_x || m_data_out_x !== prev_data)) r_stab++;
            if (frame_done) r_done_cnt++;
            if (r_n < LEN) begin
                if (!busy) r_busy_err++;
                if (s_ready) r_sready_err++;
                if (r_first >= 0 && !m_valid_x) r_bubbles++;
            end
            if (prev_free && m_valid_x && !prev_lsb) r_thr_err++;
            if (r_last >= 0 && k == r_last + 1) begin
                r_done_after   = frame_done;
                r_sready_after = s_ready;
                r_mvalid_after = m_valid_x;
            end
            if (m_valid_x && m_ready_x && r_n < LEN) begin
                rx[r_n] = m_data_out_x;
                if (m_data_out_x === 16'hDEAD) r_dead++;
                r_n++;
                if (r_n == LEN) begin
                    r_last  = k;
                    s_valid = 1'b0;
                end
            end
            prev_stall = m_valid_x && !m_ready_x;
            prev_data  = m_data_out_x;
`ifdef STREAM_FRAME_TX_THROTTLE_EN
            prev_free = !m_valid_x || m_ready_x;
            prev_lsb  = lfsr_m[0];
`endif
            if (r_last >= 0 && k >= r_last + 2) break;
            @(posedge clk); #1;
        end
        s_valid   = 1'b0;
        m_ready_x = 1'b1;
    endtask

    function automatic int count_bad(input int n, output int first);
        int bad;
        bad   = 0;
        first = 0;
        for (int i = 0; i < n; i++) begin
            if (rx[i] !== exp_q[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data_in = '0; m_ready_x = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else passed++;
        checks++; if (m_valid_x !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid_x); else passed++;
        checks++; if (m_data_out_x !== 16'h0) $display("FAIL rst_m_data: got %h want 0000", m_data_out_x); else passed++;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL rst_busy_done: got %b%b want 00", busy, frame_done); else passed++;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b want 1", s_ready); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int first, bad;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(i);
        load_frame();
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL basic_send_entry: busy=%b s_ready=%b want 1 0", busy, s_ready); else passed++;
        run_send(0, 1'b0);
        checks++; if (r_n !== LEN) $display("FAIL basic_count: got %0d want %0d", r_n, LEN); else passed++;
        bad = count_bad(r_n, first);
        checks++; if (bad !== 0)
            $display("FAIL basic_data: %0d bad, idx %0d got %h want %h", bad, first, rx[first], exp_q[first]); else passed++;
`ifndef STREAM_FRAME_TX_THROTTLE_EN
        checks++; if (r_first !== 2) $display("FAIL basic_latency: got %0d want 2", r_first); else passed++;
        checks++; if (r_last !== 65) $display("FAIL basic_last_cycle: got %0d want 65", r_last); else passed++;
`endif
        checks++; if (r_done_cnt !== 1 || r_done_after !== 1'b1)
            $display("FAIL basic_frame_done: pulses=%0d after=%b want 1 1", r_done_cnt, r_done_after); else passed++;
        checks++; if (r_sready_after !== 1'b1 || r_mvalid_after !== 1'b0)
            $display("FAIL basic_after: s_ready=%b m_valid=%b want 1 0", r_sready_after, r_mvalid_after); else passed++;
        checks++; if (r_busy_err !== 0) $display("FAIL basic_busy: %0d cycles low, want 0", r_busy_err); else passed++;
    endtask

    task automatic test_backpressure();
        int first, bad;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(i);
        load_frame();
        run_send(1, 1'b0);
        checks++; if (r_n !== LEN) $display("FAIL bp_count: got %0d want %0d", r_n, LEN); else passed++;
        bad = count_bad(r_n, first);
        checks++; if (bad !== 0)
            $display("FAIL bp_data: %0d bad, idx %0d got %h want %h", bad, first, rx[first], exp_q[first]); else passed++;
        checks++; if (r_stab !== 0) $display("FAIL bp_stability: %0d violations, want 0", r_stab); else passed++;
`ifndef STREAM_FRAME_TX_THROTTLE_EN
        checks++; if (r_last !== 128) $display("FAIL bp_last_cycle: got %0d want 128", r_last); else passed++;
`endif
        checks++; if (r_done_cnt !== 1) $display("FAIL bp_frame_done: got %0d pulses want 1", r_done_cnt); else passed++;
    endtask

    task automatic test_two_frames();
        int first, bad;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(100 + i);
        load_frame();
        run_send(0, 1'b0);
        bad = count_bad(r_n, first);
        checks++; if (r_n !== LEN || bad !== 0)
            $display("FAIL frameA_data: n=%0d bad=%0d idx %0d got %h want %h", r_n, bad, first, rx[first], exp_q[first]); else passed++;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(-1 - i);
        load_frame();
        run_send(0, 1'b0);
        bad = count_bad(r_n, first);
        checks++; if (r_n !== LEN || bad !== 0)
            $display("FAIL frameB_data: n=%0d bad=%0d idx %0d got %h want %h", r_n, bad, first, rx[first], exp_q[first]); else passed++;
        checks++; if (rx[LEN-1] !== 16'hFFC0) $display("FAIL frameB_last: got %h want ffc0", rx[LEN-1]); else passed++;
    endtask

    task automatic test_reset_mid();
        int cnt, first, bad;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1; s_data_in = 16'h7000 + 16'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0 || m_valid_x !== 1'b0)
            $display("FAIL midload_reset: s_ready=%b m_valid=%b want 0 0", s_ready, m_valid_x); else passed++;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(1000 + i);
        load_frame();
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 10; k++) begin
            m_ready_x = 1'b1;
            if (m_valid_x) begin
                rx[cnt] = m_data_out_x;
                cnt++;
            end
            @(posedge clk); #1;
        end
        bad = count_bad(cnt, first);
        checks++; if (cnt !== 10 || bad !== 0)
            $display("FAIL restart_addr0: n=%0d bad=%0d got %h want %h", cnt, bad, rx[first], exp_q[first]); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if (m_valid_x !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL midsend_reset: m_valid=%b s_ready=%b want 0 0", m_valid_x, s_ready); else passed++;
        checks++; if (busy !== 1'b0 || m_data_out_x !== 16'h0)
            $display("FAIL midsend_reset_out: busy=%b data=%h want 0 0000", busy, m_data_out_x); else passed++;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(16'h5A00 + 16'(i));
        load_frame();
        run_send(0, 1'b0);
        bad = count_bad(r_n, first);
        checks++; if (r_n !== LEN || bad !== 0)
            $display("FAIL post_reset_frame: n=%0d bad=%0d idx %0d got %h want %h", r_n, bad, first, rx[first], exp_q[first]); else passed++;
        checks++; if (r_done_cnt !== 1) $display("FAIL post_reset_done: got %0d pulses want 1", r_done_cnt); else passed++;
    endtask

    task automatic test_ignore_svalid();
        int first, bad;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(3 * i - 90);
        load_frame();
        run_send(0, 1'b1);
        checks++; if (r_sready_err !== 0) $display("FAIL send_s_ready: %0d cycles high, want 0", r_sready_err); else passed++;
        checks++; if (r_dead !== 0) $display("FAIL dead_leak: seen %0d times want 0", r_dead); else passed++;
        bad = count_bad(r_n, first);
        checks++; if (r_n !== LEN || bad !== 0)
            $display("FAIL poke_data: n=%0d bad=%0d idx %0d got %h want %h", r_n, bad, first, rx[first], exp_q[first]); else passed++;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(7 * i);
        load_frame();
        run_send(0, 1'b0);
        checks++; if (rx[0] !== 16'h0000 || rx[1] !== 16'h0007)
            $display("FAIL poke_next_frame: got %h %h want 0000 0007", rx[0], rx[1]); else passed++;
    endtask

`ifdef STREAM_FRAME_TX_THROTTLE_EN
    task automatic test_throttle();
        int first, bad;
        for (int i = 0; i < LEN; i++) exp_q[i] = sample_t'(i);
        load_frame();
        run_send(0, 1'b0);
        bad = count_bad(r_n, first);
        checks++; if (r_n !== LEN || bad !== 0)
            $display("FAIL thr_data: n=%0d bad=%0d idx %0d got %h want %h", r_n, bad, first, rx[first], exp_q[first]); else passed++;
        checks++; if (r_bubbles < 1) $display("FAIL thr_bubbles: got %0d want >=1", r_bubbles); else passed++;
        checks++; if (r_thr_err !== 0) $display("FAIL thr_lfsr_gate: %0d bad rises want 0", r_thr_err); else passed++;
        checks++; if (r_stab !== 0) $display("FAIL thr_stability: %0d violations want 0", r_stab); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_two_frames();
        test_reset_mid();
        test_ignore_svalid();
`ifdef STREAM_FRAME_TX_THROTTLE_EN
        test_throttle();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
